// File: rtl/alu_pkg.sv
// alu_pkg: opcode set, default widths and a reference ALU function for the pipelined ALU
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_OP_WIDTH   = 3;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SHL,
        ALU_SHR,
        ALU_LTU
    } alu_op_e;

    // Golden ALU at the default width; shifts by >= width naturally yield zero
    function automatic logic [DEFAULT_DATA_WIDTH-1:0] alu_golden(
        input logic [DEFAULT_DATA_WIDTH-1:0] a,
        input logic [DEFAULT_DATA_WIDTH-1:0] b,
        input alu_op_e                       op
    );
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SHL: return a << b;
            ALU_SHR: return a >> b;
            ALU_LTU: return {{(DEFAULT_DATA_WIDTH-1){1'b0}}, a < b};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_func_unit.sv
// alu_func_unit: purely combinational ALU evaluating the operands held in stage 1
module alu_func_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            op,
    output logic [DATA_WIDTH-1:0] result
);

    // Shift amounts use the full value of b, so b >= DATA_WIDTH clears the result
    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SHL: result = a << b;
            ALU_SHR: result = a >> b;
            ALU_LTU: result = {{(DATA_WIDTH-1){1'b0}}, a < b};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: two-stage valid/ready ALU pipeline (operand stage, result stage)
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OP_WIDTH   = DEFAULT_OP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0]   op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;
    logic [OP_WIDTH-1:0]   s1_op;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] fu_result;
    logic                  advance;
    logic                  in_fire;
    logic                  out_fire;

    alu_func_unit #(.DATA_WIDTH(DATA_WIDTH)) u_func (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op[2:0]),
        .result (fu_result)
    );

    // Stage 1 moves on when stage 2 is empty or draining; ready depends on out_ready, never on in_valid
    always_comb begin
        advance  = s1_valid && (!out_valid || out_ready);
        in_ready = !rst && (!s1_valid || !out_valid || out_ready);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    // Operand stage: load on input transfer, otherwise empty out once its op has advanced
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= op;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Result stage: capture the ALU output on advance; result is held whenever nothing new arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (advance) begin
            out_valid <= 1'b1;
            result    <= fu_result;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_core.sv
// tb_alu_pipe_core: directed vectors checked against an in-order queue model every cycle
module tb_alu_pipe_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;

    alu_pipe_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        int         acc;
    } ent_t;

    ent_t       q[$];
    logic [7:0] lit_q[$];
    logic [7:0] cur_lit = '0;
    logic [7:0] last = '0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    logic       s_rst = 1'b1;
    logic       s_in = 1'b0;
    logic       s_out = 1'b0;
    logic       rst_prev = 1'b1;
    logic [7:0] s_res = '0;
    logic [7:0] s_lit = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int xi = int'(x);
        int yi = int'(y);
        int r;
        case (o)
            3'd0: r = (xi + yi) % 256;
            3'd1: r = (xi - yi + 256) % 256;
            3'd2: r = int'(x & y);
            3'd3: r = int'(x | y);
            3'd4: r = int'(x ^ y);
            3'd5: r = (yi >= 8) ? 0 : (xi * (2 ** yi)) % 256;
            3'd6: r = (yi >= 8) ? 0 : xi / (2 ** yi);
            default: r = (xi < yi) ? 1 : 0;
        endcase
        return r[7:0];
    endfunction

    // Compare DUT against the model mid-cycle and latch what the next edge will transfer
    always @(negedge clk) begin
        s_rst = rst;
        s_in  = in_valid && in_ready;
        s_out = out_valid && out_ready;
        s_res = model(op, a, b);
        s_lit = cur_lit;
        if (cyc > 0) begin
            if (rst) begin
                chk("rst_in_ready", in_ready, 0);
                if (rst_prev) begin
                    chk("rst_out_valid", out_valid, 0);
                    chk("rst_result", result, 0);
                end
            end else begin
                logic exp_ov;
                exp_ov = q.size() > 0 && q[0].acc < cyc;
                chk("in_ready", in_ready, (q.size() < 2) || out_ready);
                chk("out_valid", out_valid, exp_ov);
                if (exp_ov) last = q[0].res;
                chk("result", result, last);
                if (s_out && lit_q.size() > 0) chk("literal", result, lit_q[0]);
            end
        end
    end

    // Apply the transfers of this edge to the model
    always @(posedge clk) begin
        cyc++;
        rst_prev = s_rst;
        if (s_rst) begin
            q.delete();
            lit_q.delete();
            last = '0;
        end else begin
            if (s_out && q.size() > 0) begin
                void'(q.pop_front());
                if (lit_q.size() > 0) void'(lit_q.pop_front());
            end
            if (s_in) begin
                q.push_back('{s_res, cyc});
                lit_q.push_back(s_lit);
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic [7:0] e);
        int   t = 0;
        logic ok;
        op = o;
        a = x;
        b = y;
        cur_lit = e;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            step();
            t++;
        end while (!ok && t < 100);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 100 cycles");
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0] o;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] e;
    } vec_t;

    vec_t stream_v[8] = '{
        '{3'd0, 8'h01, 8'h01, 8'h02},
        '{3'd1, 8'h00, 8'h01, 8'hFF},
        '{3'd2, 8'hF0, 8'h3C, 8'h30},
        '{3'd3, 8'hF0, 8'h0F, 8'hFF},
        '{3'd4, 8'hAA, 8'hFF, 8'h55},
        '{3'd5, 8'h01, 8'h03, 8'h08},
        '{3'd6, 8'h80, 8'h04, 8'h08},
        '{3'd7, 8'h02, 8'h03, 8'h01}
    };

    vec_t corner_v[6] = '{
        '{3'd5, 8'h81, 8'h01, 8'h02},
        '{3'd6, 8'h80, 8'h08, 8'h00},
        '{3'd5, 8'h01, 8'hFF, 8'h00},
        '{3'd7, 8'h03, 8'h05, 8'h01},
        '{3'd7, 8'h05, 8'h05, 8'h00},
        '{3'd0, 8'hFF, 8'h01, 8'h00}
    };

    vec_t bp_v[5] = '{
        '{3'd0, 8'h10, 8'h20, 8'h30},
        '{3'd1, 8'h50, 8'h10, 8'h40},
        '{3'd4, 8'h0F, 8'hF0, 8'hFF},
        '{3'd3, 8'h01, 8'h02, 8'h03},
        '{3'd2, 8'hFF, 8'h0F, 8'h0F}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   idx;
        int   n0;
        logic took;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        step();

        send(3'd0, 8'hF0, 8'h20, 8'h10);
        @(negedge clk);
        chk("single_n1_out_valid", out_valid, 0);
        @(negedge clk);
        chk("single_n2_out_valid", out_valid, 1);
        chk("single_n2_result", result, 8'h10);
        @(negedge clk);
        chk("single_n3_out_valid", out_valid, 0);
        step();

        foreach (stream_v[i]) send(stream_v[i].o, stream_v[i].x, stream_v[i].y, stream_v[i].e);
        repeat (3) step();
        foreach (corner_v[i]) send(corner_v[i].o, corner_v[i].x, corner_v[i].y, corner_v[i].e);
        repeat (3) step();

        out_ready = 1'b0;
        n0 = acc_cnt;
        idx = 0;
        op = bp_v[0].o;
        a = bp_v[0].x;
        b = bp_v[0].y;
        cur_lit = bp_v[0].e;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            took = in_ready;
            step();
            if (took) begin
                idx++;
                op = bp_v[idx].o;
                a = bp_v[idx].x;
                b = bp_v[idx].y;
                cur_lit = bp_v[idx].e;
            end
        end
        chk("bp_accepted", acc_cnt - n0, 2);
        @(negedge clk);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_result_held", result, 8'h30);
        step();
        out_ready = 1'b1;
        for (int i = idx; i < 5; i++) send(bp_v[i].o, bp_v[i].x, bp_v[i].y, bp_v[i].e);
        repeat (4) step();
        chk("bp_all_accepted", acc_cnt - n0, 5);

        out_ready = 1'b0;
        send(3'd0, 8'h03, 8'h04, 8'h07);
        send(3'd1, 8'h09, 8'h02, 8'h07);
        @(negedge clk);
        chk("sim_full_in_ready", in_ready, 0);
        step();
        out_ready = 1'b1;
        op = 3'd4;
        a = 8'h0C;
        b = 8'h0A;
        cur_lit = 8'h06;
        in_valid = 1'b1;
        @(negedge clk);
        chk("sim_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("sim_out_valid", out_valid, 1);
        chk("sim_result", result, 8'h07);
        chk("sim_still_full", in_ready, 0);
        step();
        out_ready = 1'b1;
        repeat (4) step();

        out_ready = 1'b0;
        send(3'd0, 8'h11, 8'h22, 8'h33);
        send(3'd0, 8'h44, 8'h11, 8'h55);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", in_ready, 1);
        chk("rst_release_out_valid", out_valid, 0);
        chk("rst_release_result", result, 0);
        step();
        repeat (3) step();
        send(3'd0, 8'h02, 8'h03, 8'h05);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
